echo_drain: RTL and testbench
=============================

ECHO_DRAIN -- requirements
Module: echo_drain

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: ports CLK and nRST.
REQ-002 SHALL have these ports:
- CLK  in  1  clock; all state changes on posedge
- nRST  in  1  async active-low reset
- fifo_first  in  32  head word of upstream Fifo
- fifo_first__RDY  in  1  head word valid
- fifo_deq__RDY  in  1  upstream Fifo can dequeue
- fifo_deq__ENA  out  1  dequeue strobe to upstream Fifo
- setDelay__ENA  in  1  delay-config method call
- setDelay_v  in  8  new delay, in cycles
- setDelay__RDY  out  1  delay config accepted this cycle
- ind_heard__ENA  out  1  indication call, word delivered
- ind_heard_v  out  32  delivered word
- ind_heard__RDY  in  1  downstream indication can accept
- count  out  16  words delivered since reset
- count__RDY  out  1  count readable, constant 1
REQ-003 SHALL treat every ENA/RDY pair as a guarded method: it SHALL assert an ENA only when the matching RDY is high in the same cycle, and it SHALL require the same of callers.

Function
REQ-004 SHALL implement a three-state FSM with states IDLE, WAIT and SEND, and registers data[31:0], timer[7:0], delay[7:0] and count[15:0].
REQ-005 IDLE: when fifo_first__RDY and fifo_deq__RDY are both high, SHALL drive fifo_deq__ENA=1 combinationally, capture fifo_first into data, load timer from delay, and go to WAIT if delay!=0, else go to SEND.
REQ-006 WAIT: timer SHALL decrement once per cycle, and the FSM SHALL go to SEND on the cycle timer==1; a delay d therefore gives exactly d cycles in WAIT.
REQ-007 SEND: ind_heard__ENA SHALL equal ind_heard__RDY (combinational); ind_heard_v SHALL equal data throughout WAIT and SEND.
REQ-008 SEND handshake cycle: count SHALL increment modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-009 SEND handshake cycle, upstream word available and delay==0: SHALL dequeue and capture the next word and stay in SEND, giving one word per cycle.
REQ-010 SEND handshake cycle, upstream word available and delay!=0: SHALL dequeue, capture and go to WAIT.
REQ-011 SEND handshake cycle, no upstream word available: SHALL go to IDLE.
REQ-012 SEND with ind_heard__RDY low: SHALL hold state and data and SHALL NOT dequeue.
REQ-013 setDelay__RDY SHALL be high only in IDLE; setDelay__ENA SHALL load setDelay_v into delay at the clock edge.
REQ-014 When setDelay and a capture happen in the same IDLE cycle, the captured word SHALL use the old delay, and the new delay SHALL apply from the next word.
REQ-015 fifo_deq__ENA SHALL be low in WAIT and in SEND without a handshake; no upstream word is ever dequeued without being delivered, except when reset intervenes.
REQ-016 Latency, Fifo head to ind_heard__ENA with downstream ready: 1 cycle + delay.

Reset
REQ-017 nRST low SHALL asynchronously force state=IDLE, data=0, timer=0, delay=0 and count=0.
REQ-018 During reset: fifo_deq__ENA=0, ind_heard__ENA=0, ind_heard_v=0, count=0, setDelay__RDY=1, count__RDY=1.
REQ-019 Reset asserted in WAIT or SEND SHALL drop the in-flight word, which is not delivered and not counted.
REQ-020 After nRST deasserts, the first capture SHALL occur no earlier than the first posedge at which nRST is high.

Structure
REQ-021 Shared package echo_pkg SHALL hold: state enum (IDLE/WAIT/SEND), DATA_W=32, DELAY_W=8, COUNT_W=16.
REQ-022 The timer SHALL be one sub-module, echo_delay_timer, a loadable down-counter with a terminal-count output; the FSM, data and count registers stay in echo_drain.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Delay 0, Fifo holds 0x11,0x22,0x33, ind_heard__RDY=1 -> deq on 3 consecutive cycles; heard 0x11,0x22,0x33 back-to-back, one cycle after the first deq; count=3.
- setDelay(4), then push 0xDEADBEEF -> deq in cycle t; heard__ENA in cycle t+5; WAIT lasts exactly 4 cycles.
- Delay 0, word 0xA5A5A5A5, ind_heard__RDY low for 6 cycles -> ind_heard_v stable at 0xA5A5A5A5; no further deq; delivered once when RDY rises; count=1.
- setDelay(3) and capture of 0x01 in the same IDLE cycle, delay previously 0 -> 0x01 goes straight to SEND; next word 0x02 waits 3 cycles.
- Force count=0xFFFF, then deliver one word -> count=0x0000.
- nRST pulsed low mid-WAIT (delay 5, word 0x77) -> heard never fires for 0x77; count=0; delay=0; setDelay__RDY=1 immediately, asynchronously.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types and widths for the echo_drain block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package echo_pkg;
    localparam int DATA_W  = 32;
    localparam int DELAY_W = 8;
    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;
endpackage

// File: rtl/echo_delay_timer.sv
// Loadable down-counter; tc flags the last cycle of a programmed wait.
// Latency: load/decrement take effect at the next clock edge.
// Backpressure: none; dec is ignored once the counter reaches zero.
module echo_delay_timer
    import echo_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_val,
    input  logic               dec,
    output logic               tc
);

    logic [DELAY_W-1:0] timer_q;
    logic [DELAY_W-1:0] timer_d;

    // Load has priority over decrement; never wrap below zero.
    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = load_val;
        end else if (dec && (timer_q != '0)) begin
            timer_d = timer_q - DELAY_W'(1);
        end
    end

    // Timer register, cleared by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Terminal count: this is the final wait cycle.
    assign tc = (timer_q == DELAY_W'(1));

endmodule

// File: rtl/echo_drain.sv
// Drains words from an upstream Fifo and echoes each one on ind_heard after a programmable delay.
// Latency: Fifo head to ind_heard__ENA is 1 cycle + delay when downstream is ready.
// Backpressure: ind_heard__RDY low holds the word in SEND and stops further dequeues.
module echo_drain
    import echo_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic [DATA_W-1:0]  fifo_first,
    input  logic               fifo_first__RDY,
    input  logic               fifo_deq__RDY,
    output logic               fifo_deq__ENA,
    input  logic               setDelay__ENA,
    input  logic [DELAY_W-1:0] setDelay_v,
    output logic               setDelay__RDY,
    output logic               ind_heard__ENA,
    output logic [DATA_W-1:0]  ind_heard_v,
    input  logic               ind_heard__RDY,
    output logic [COUNT_W-1:0] count,
    output logic               count__RDY
);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic word_avail;
    logic timer_load;
    logic timer_dec;
    logic timer_tc;
    logic deq_ena;
    logic heard_ena;

    // Gating with nRST keeps a capture from happening while reset is still held.
    assign word_avail = fifo_first__RDY & fifo_deq__RDY & nRST;

    echo_delay_timer u_timer (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (timer_load),
        .load_val (delay_q),
        .dec      (timer_dec),
        .tc       (timer_tc)
    );

    // Next-state, datapath and strobe decode; captures always use the delay already registered.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        delay_d    = delay_q;
        count_d    = count_q;
        deq_ena    = 1'b0;
        heard_ena  = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        if (setDelay__ENA && (state_q == IDLE)) begin
            delay_d = setDelay_v;
        end

        case (state_q)
            IDLE: begin
                if (word_avail) begin
                    deq_ena    = 1'b1;
                    data_d     = fifo_first;
                    timer_load = 1'b1;
                    state_d    = (delay_q != '0) ? WAIT : SEND;
                end
            end
            WAIT: begin
                timer_dec = 1'b1;
                if (timer_tc) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                heard_ena = ind_heard__RDY;
                if (ind_heard__RDY) begin
                    count_d = count_q + COUNT_W'(1);
                    if (word_avail) begin
                        deq_ena    = 1'b1;
                        data_d     = fifo_first;
                        timer_load = 1'b1;
                        state_d    = (delay_q != '0) ? WAIT : SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight word.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            data_q  <= '0;
            delay_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            delay_q <= delay_d;
            count_q <= count_d;
        end
    end

    assign fifo_deq__ENA  = deq_ena;
    assign ind_heard__ENA = heard_ena;
    assign ind_heard_v    = data_q;
    assign setDelay__RDY  = (state_q == IDLE);
    assign count          = count_q;
    assign count__RDY     = 1'b1;

endmodule

// File: tb/tb_echo_drain.sv
// Directed self-checking bench for echo_drain with a queue-based upstream Fifo model.
// Latency: inputs change on negedge, outputs sampled 4 time units later, before the posedge.
// Backpressure: ind_heard__RDY driven directly by each scenario task.
module tb_echo_drain;
    import echo_pkg::*;

    logic               CLK;
    logic               nRST;
    logic [DATA_W-1:0]  fifo_first;
    logic               fifo_first__RDY;
    logic               fifo_deq__RDY;
    logic               fifo_deq__ENA;
    logic               setDelay__ENA;
    logic [DELAY_W-1:0] setDelay_v;
    logic               setDelay__RDY;
    logic               ind_heard__ENA;
    logic [DATA_W-1:0]  ind_heard_v;
    logic               ind_heard__RDY;
    logic [COUNT_W-1:0] count;
    logic               count__RDY;

    echo_drain dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .fifo_first      (fifo_first),
        .fifo_first__RDY (fifo_first__RDY),
        .fifo_deq__RDY   (fifo_deq__RDY),
        .fifo_deq__ENA   (fifo_deq__ENA),
        .setDelay__ENA   (setDelay__ENA),
        .setDelay_v      (setDelay_v),
        .setDelay__RDY   (setDelay__RDY),
        .ind_heard__ENA  (ind_heard__ENA),
        .ind_heard_v     (ind_heard_v),
        .ind_heard__RDY  (ind_heard__RDY),
        .count           (count),
        .count__RDY      (count__RDY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    logic [DATA_W-1:0] fq[$];
    int                deq_cyc[$];
    int                heard_cyc[$];
    logic [DATA_W-1:0] heard_val[$];

    logic               s_deq, s_hen, s_sdr;
    logic [DATA_W-1:0]  s_hv;

    task automatic refresh_inputs();
        fifo_first__RDY = (fq.size() != 0);
        fifo_first      = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic clear_logs();
        deq_cyc.delete();
        heard_cyc.delete();
        heard_val.delete();
    endtask

    // One clock cycle: called right after a negedge with inputs set.
    task automatic cyc();
        #4;
        s_deq = fifo_deq__ENA;
        s_hen = ind_heard__ENA;
        s_hv  = ind_heard_v;
        s_sdr = setDelay__RDY;
        if (s_deq) deq_cyc.push_back(cyc_n);
        if (s_hen) begin
            heard_cyc.push_back(cyc_n);
            heard_val.push_back(s_hv);
        end
        @(posedge CLK);
        if (s_deq && fq.size() != 0) void'(fq.pop_front());
        @(negedge CLK);
        cyc_n++;
        refresh_inputs();
    endtask

    task automatic do_reset();
        nRST           = 1'b0;
        fq.delete();
        ind_heard__RDY = 1'b1;
        setDelay__ENA  = 1'b0;
        setDelay_v     = '0;
        refresh_inputs();
        cyc();
        cyc();
        nRST = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        int t0;
        nRST = 1'b0;
        fq.push_back(32'hCAFE_F00D);
        refresh_inputs();
        cyc();
        #2;
        checks++; if (fifo_deq__ENA !== 1'b0) begin failures++; $display("FAIL reset_deq got=%b exp=0", fifo_deq__ENA); end
        checks++; if (ind_heard__ENA !== 1'b0) begin failures++; $display("FAIL reset_heard_ena got=%b exp=0", ind_heard__ENA); end
        checks++; if (ind_heard_v !== 32'h0) begin failures++; $display("FAIL reset_heard_v got=%h exp=0", ind_heard_v); end
        checks++; if (count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", count); end
        checks++; if (setDelay__RDY !== 1'b1) begin failures++; $display("FAIL reset_setdelay_rdy got=%b exp=1", setDelay__RDY); end
        checks++; if (count__RDY !== 1'b1) begin failures++; $display("FAIL reset_count_rdy got=%b exp=1", count__RDY); end
        @(negedge CLK);
        cyc_n++;
        clear_logs();
        nRST = 1'b1;
        t0 = cyc_n;
        for (int i = 0; i < 3; i++) cyc();
        checks++; if (deq_cyc.size() != 1 || deq_cyc[0] != t0) begin failures++; $display("FAIL reset_first_capture got_n=%0d exp_n=1 at %0d", deq_cyc.size(), t0); end
    endtask

    task automatic test_back_to_back();
        int t0;
        do_reset();
        fq.push_back(32'h11); fq.push_back(32'h22); fq.push_back(32'h33);
        refresh_inputs();
        t0 = cyc_n;
        for (int i = 0; i < 6; i++) cyc();
        checks++; if (deq_cyc.size() != 3) begin failures++; $display("FAIL b2b_deq_n got=%0d exp=3", deq_cyc.size()); end
        checks++; if (heard_val.size() != 3) begin failures++; $display("FAIL b2b_heard_n got=%0d exp=3", heard_val.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [DATA_W-1:0] ev;
            ev = 32'h11 * (i + 1);
            checks++; if (i >= deq_cyc.size() || deq_cyc[i] != t0 + i) begin failures++; $display("FAIL b2b_deq_cyc[%0d] exp=%0d", i, t0 + i); end
            checks++; if (i >= heard_val.size() || heard_val[i] !== ev || heard_cyc[i] != t0 + 1 + i) begin failures++; $display("FAIL b2b_heard[%0d] exp=%h at %0d", i, ev, t0 + 1 + i); end
        end
        checks++; if (count !== 16'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", count); end
    endtask

    task automatic test_delay();
        int t0;
        logic [DATA_W-1:0] mid_v;
        logic mid_sdr;
        mid_v = '0; mid_sdr = 1'b1;
        do_reset();
        setDelay__ENA = 1'b1; setDelay_v = 8'd4;
        cyc();
        setDelay__ENA = 1'b0;
        fq.push_back(32'hDEAD_BEEF);
        refresh_inputs();
        t0 = cyc_n;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (i == 2) begin mid_v = s_hv; mid_sdr = s_sdr; end
        end
        checks++; if (deq_cyc.size() != 1 || deq_cyc[0] != t0) begin failures++; $display("FAIL delay4_deq got_n=%0d exp at %0d", deq_cyc.size(), t0); end
        checks++; if (heard_cyc.size() != 1 || heard_cyc[0] != t0 + 5) begin failures++; $display("FAIL delay4_heard_cyc got_n=%0d exp at %0d", heard_cyc.size(), t0 + 5); end
        checks++; if (heard_val.size() != 1 || heard_val[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL delay4_heard_v exp=deadbeef"); end
        checks++; if (mid_v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL delay4_wait_v got=%h exp=deadbeef", mid_v); end
        checks++; if (mid_sdr !== 1'b0) begin failures++; $display("FAIL delay4_wait_setdelay_rdy got=%b exp=0", mid_sdr); end
    endtask

    task automatic test_stall();
        int t0;
        int stable;
        do_reset();
        ind_heard__RDY = 1'b0;
        fq.push_back(32'hA5A5_A5A5);
        refresh_inputs();
        cyc();
        fq.push_back(32'h1234_5678);
        refresh_inputs();
        stable = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (s_hv === 32'hA5A5_A5A5 && !s_hen && !s_deq) stable++;
        end
        checks++; if (stable != 6) begin failures++; $display("FAIL stall_hold got=%0d exp=6", stable); end
        checks++; if (deq_cyc.size() != 1 || heard_cyc.size() != 0) begin failures++; $display("FAIL stall_no_deq deq=%0d heard=%0d exp=1/0", deq_cyc.size(), heard_cyc.size()); end
        ind_heard__RDY = 1'b1;
        t0 = cyc_n;
        cyc();
        checks++; if (heard_val.size() != 1 || heard_val[0] !== 32'hA5A5_A5A5 || heard_cyc[0] != t0) begin failures++; $display("FAIL stall_release_heard n=%0d exp=1 a5a5a5a5 at %0d", heard_val.size(), t0); end
        checks++; if (count !== 16'd1) begin failures++; $display("FAIL stall_count got=%0d exp=1", count); end
        for (int i = 0; i < 3; i++) cyc();
        checks++; if (count !== 16'd2 || heard_val.size() != 2) begin failures++; $display("FAIL stall_drain count=%0d exp=2", count); end
    endtask

    task automatic test_same_cycle_delay();
        int t0;
        do_reset();
        fq.push_back(32'h01); fq.push_back(32'h02);
        refresh_inputs();
        setDelay__ENA = 1'b1; setDelay_v = 8'd3;
        t0 = cyc_n;
        cyc();
        setDelay__ENA = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        checks++; if (deq_cyc.size() != 2 || deq_cyc[0] != t0 || deq_cyc[1] != t0 + 1) begin failures++; $display("FAIL samecyc_deq n=%0d exp=2 at %0d,%0d", deq_cyc.size(), t0, t0 + 1); end
        checks++; if (heard_cyc.size() != 2 || heard_cyc[0] != t0 + 1 || heard_val[0] !== 32'h01) begin failures++; $display("FAIL samecyc_first n=%0d exp 01 at %0d", heard_cyc.size(), t0 + 1); end
        checks++; if (heard_cyc.size() != 2 || heard_cyc[1] != t0 + 5 || heard_val[1] !== 32'h02) begin failures++; $display("FAIL samecyc_second n=%0d exp 02 at %0d", heard_cyc.size(), t0 + 5); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        #1;
        checks++; if (count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", count); end
        @(negedge CLK);
        cyc_n++;
        fq.push_back(32'h0BAD_F00D);
        refresh_inputs();
        for (int i = 0; i < 3; i++) cyc();
        checks++; if (count !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", count); end
        checks++; if (heard_val.size() != 1) begin failures++; $display("FAIL wrap_heard_n got=%0d exp=1", heard_val.size()); end
    endtask

    task automatic test_reset_mid_wait();
        int t0;
        do_reset();
        setDelay__ENA = 1'b1; setDelay_v = 8'd5;
        cyc();
        setDelay__ENA = 1'b0;
        fq.push_back(32'h77);
        refresh_inputs();
        cyc();
        cyc();
        cyc();
        #2;
        nRST = 1'b0;
        #1;
        checks++; if (setDelay__RDY !== 1'b1) begin failures++; $display("FAIL rstwait_setdelay_rdy got=%b exp=1", setDelay__RDY); end
        checks++; if (count !== 16'h0 || ind_heard_v !== 32'h0) begin failures++; $display("FAIL rstwait_clear count=%h v=%h exp=0/0", count, ind_heard_v); end
        @(negedge CLK);
        cyc_n++;
        nRST = 1'b1;
        fq.push_back(32'h88);
        refresh_inputs();
        t0 = cyc_n;
        for (int i = 0; i < 10; i++) cyc();
        checks++; if (heard_val.size() != 1 || heard_val[0] !== 32'h88) begin failures++; $display("FAIL rstwait_dropped n=%0d exp=1 word 88", heard_val.size()); end
        checks++; if (heard_cyc.size() != 1 || heard_cyc[0] != t0 + 1) begin failures++; $display("FAIL rstwait_delay_cleared exp heard at %0d", t0 + 1); end
        checks++; if (count !== 16'd1) begin failures++; $display("FAIL rstwait_count got=%0d exp=1", count); end
    endtask

    initial begin
        nRST           = 1'b0;
        fifo_deq__RDY  = 1'b1;
        ind_heard__RDY = 1'b1;
        setDelay__ENA  = 1'b0;
        setDelay_v     = '0;
        refresh_inputs();
        @(negedge CLK);
        test_reset();
        test_back_to_back();
        test_delay();
        test_stall();
        test_same_cycle_delay();
        test_count_wrap();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
